// File: rtl/writeback.sv
// writeback -- final pipeline stage.
//   Captures the EX-stage WB_*_next bundle into the WB latch and, in the
//   following cycle, commits the GPR result, the masked EFLAGS bits and the
//   dcache write. WB_STALL holds EX and the latch while a store is blocked.
//   Optional REP/REPNE iteration handling is built when WB_REP_EN is defined.
//   In that build, ECX is decremented and fetch is redirected back to the
//   string instruction, followed by a FLUSH_CYCLES squash window.
// Ports:
//   CLK, RST (async, active-low)
//   WB_*_next             EX-stage payload for the WB latch
//   DCACHE_READY          dcache accepts a write this cycle
//   WB_STALL              hold EX and the WB latch
//   GPR_WE/DR/DATA/SIZE   register-file write (lane merge done by the RF)
//   DCACHE_WE/WDATA       memory write
//   ECX_WE/ECX_DATA       count write-back (REP builds only)
//   EFLAGS                architectural flags register
//   REP_REDIRECT/EIP      one-cycle fetch redirect (REP builds only)
// Commit strobes are combinational from the latch contents.
module writeback #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WB_V_next,
  input  logic [31:0] WB_CUR_EIP_next,
  input  logic [31:0] WB_NEIP_next,
  input  logic [1:0]  WB_de_datasize_all_next,
  input  logic        WB_de_ld_gpr1_wb_next,
  input  logic        WB_de_dcache_write_wb_next,
  input  logic [6:0]  WB_de_flags_affected_wb_next,
  input  logic [31:0] WB_ALU32_RESULT_next,
  input  logic [31:0] WB_FLAGS_next,
  input  logic [31:0] WB_COUNT_next,
  input  logic [2:0]  WB_DR1_next,
  input  logic        WB_IS_REP_next,
  input  logic        WB_IS_REPNE_next,
  input  logic        DCACHE_READY,
  output logic        WB_STALL,
  output logic        GPR_WE,
  output logic [2:0]  GPR_DR,
  output logic [31:0] GPR_DATA,
  output logic [1:0]  GPR_SIZE,
  output logic        DCACHE_WE,
  output logic [31:0] DCACHE_WDATA,
  output logic        ECX_WE,
  output logic [31:0] ECX_DATA,
  output logic [31:0] EFLAGS,
  output logic        REP_REDIRECT,
  output logic [31:0] REDIRECT_EIP
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_SQUASH   = 2'd2;

  localparam logic [XLEN-1:0] EFLAGS_RST = 32'h0000_0002;

  // WB latch
  logic            v_q, v_d;
  logic [1:0]      size_q, size_d;
  logic            ld_gpr1_q, ld_gpr1_d;
  logic            dc_wr_q, dc_wr_d;
  logic [6:0]      mask_q, mask_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [6:0]      aflags_q, aflags_d;   // ALU flags packed in mask order
  logic [2:0]      dr1_q, dr1_d;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] eflags_q, eflags_d;

  logic            stall_c, commit_c, wr_en_c, rep_zero_c;
  logic            ecx_we_c, redirect_c;

`ifdef WB_REP_EN
  logic [XLEN-1:0] cur_eip_q, cur_eip_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            is_rep_q, is_rep_d;
  logic            is_repne_q, is_repne_d;
  logic [CNT_W-1:0] sq_cnt_q, sq_cnt_d;
  logic [XLEN-1:0] ecx_new_c;
  logic            rep_any_c, terminate_c;
`endif

  // Inputs that are only carried or only partly consumed
  logic unused_c;
`ifdef WB_REP_EN
  assign unused_c = ^{WB_NEIP_next, WB_FLAGS_next[31:12], WB_FLAGS_next[9:8],
                      WB_FLAGS_next[5], WB_FLAGS_next[3], WB_FLAGS_next[1]};
`else
  assign unused_c = ^{WB_NEIP_next, WB_FLAGS_next[31:12], WB_FLAGS_next[9:8],
                      WB_FLAGS_next[5], WB_FLAGS_next[3], WB_FLAGS_next[1],
                      WB_CUR_EIP_next, WB_COUNT_next, WB_IS_REP_next,
                      WB_IS_REPNE_next, CNT_W[0], FLUSH_CYCLES[0]};
`endif

  // Stall / commit qualification; a REP with zero count retires with no write
  always_comb begin
`ifdef WB_REP_EN
    rep_any_c  = is_rep_q | is_repne_q;
    rep_zero_c = rep_any_c & (count_q == '0);
`else
    rep_zero_c = 1'b0;
`endif
    stall_c  = (state_q != ST_SQUASH) & v_q & dc_wr_q & ~rep_zero_c & ~DCACHE_READY;
    commit_c = v_q & (state_q != ST_SQUASH) & ~stall_c;
    wr_en_c  = commit_c & ~rep_zero_c;
  end

  // Latch next-state: capture the EX bundle unless stalled
  always_comb begin
    v_d       = v_q;
    size_d    = size_q;
    ld_gpr1_d = ld_gpr1_q;
    dc_wr_d   = dc_wr_q;
    mask_d    = mask_q;
    result_d  = result_q;
    aflags_d  = aflags_q;
    dr1_d     = dr1_q;
`ifdef WB_REP_EN
    cur_eip_d  = cur_eip_q;
    count_d    = count_q;
    is_rep_d   = is_rep_q;
    is_repne_d = is_repne_q;
`endif
    if (!stall_c) begin
      v_d       = WB_V_next;
      size_d    = WB_de_datasize_all_next;
      ld_gpr1_d = WB_de_ld_gpr1_wb_next;
      dc_wr_d   = WB_de_dcache_write_wb_next;
      mask_d    = WB_de_flags_affected_wb_next;
      result_d  = WB_ALU32_RESULT_next;
      aflags_d  = {WB_FLAGS_next[11], WB_FLAGS_next[10], WB_FLAGS_next[7],
                   WB_FLAGS_next[6], WB_FLAGS_next[4], WB_FLAGS_next[2],
                   WB_FLAGS_next[0]};
      dr1_d     = WB_DR1_next;
`ifdef WB_REP_EN
      cur_eip_d  = WB_CUR_EIP_next;
      count_d    = WB_COUNT_next;
      is_rep_d   = WB_IS_REP_next;
      is_repne_d = WB_IS_REPNE_next;
`endif
    end
  end

  // EFLAGS merge: mask bit i selects EFLAGS bit {0,2,4,6,7,10,11}[i]
  always_comb begin
    eflags_d = eflags_q;
    if (wr_en_c) begin
      if (mask_q[0]) eflags_d[0]  = aflags_q[0];
      if (mask_q[1]) eflags_d[2]  = aflags_q[1];
      if (mask_q[2]) eflags_d[4]  = aflags_q[2];
      if (mask_q[3]) eflags_d[6]  = aflags_q[3];
      if (mask_q[4]) eflags_d[7]  = aflags_q[4];
      if (mask_q[5]) eflags_d[10] = aflags_q[5];
      if (mask_q[6]) eflags_d[11] = aflags_q[6];
    end
    eflags_d[1] = 1'b1;
  end

  // REP iteration: decrement ECX, redirect unless count exhausted or REPNE hit ZF
`ifdef WB_REP_EN
  always_comb begin
    ecx_new_c   = count_q - 32'd1;
    terminate_c = (ecx_new_c == '0) | (is_repne_q & eflags_d[6]);
    ecx_we_c    = commit_c & rep_any_c & ~rep_zero_c;
    redirect_c  = ecx_we_c & ~terminate_c;
  end
`else
  always_comb begin
    ecx_we_c   = 1'b0;
    redirect_c = 1'b0;
  end
`endif

  // FSM next-state
  always_comb begin
    state_d = state_q;
`ifdef WB_REP_EN
    sq_cnt_d = sq_cnt_q;
`endif
    case (state_q)
      ST_RUN: begin
`ifdef WB_REP_EN
        if (redirect_c) begin
          state_d  = ST_SQUASH;
          sq_cnt_d = CNT_W'(FLUSH_CYCLES);
        end else
`endif
        if (stall_c) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
`ifdef WB_REP_EN
        if (redirect_c) begin
          state_d  = ST_SQUASH;
          sq_cnt_d = CNT_W'(FLUSH_CYCLES);
        end else
`endif
        if (!stall_c) state_d = ST_RUN;
      end
`ifdef WB_REP_EN
      ST_SQUASH: begin
        sq_cnt_d = sq_cnt_q - CNT_W'(1);
        if (sq_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  // State registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_q       <= 1'b0;
      size_q    <= '0;
      ld_gpr1_q <= 1'b0;
      dc_wr_q   <= 1'b0;
      mask_q    <= '0;
      result_q  <= '0;
      aflags_q  <= '0;
      dr1_q     <= '0;
      state_q   <= ST_RUN;
      eflags_q  <= EFLAGS_RST;
    end else begin
      v_q       <= v_d;
      size_q    <= size_d;
      ld_gpr1_q <= ld_gpr1_d;
      dc_wr_q   <= dc_wr_d;
      mask_q    <= mask_d;
      result_q  <= result_d;
      aflags_q  <= aflags_d;
      dr1_q     <= dr1_d;
      state_q   <= state_d;
      eflags_q  <= eflags_d;
    end
  end

`ifdef WB_REP_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_eip_q  <= '0;
      count_q    <= '0;
      is_rep_q   <= 1'b0;
      is_repne_q <= 1'b0;
      sq_cnt_q   <= '0;
    end else begin
      cur_eip_q  <= cur_eip_d;
      count_q    <= count_d;
      is_rep_q   <= is_rep_d;
      is_repne_q <= is_repne_d;
      sq_cnt_q   <= sq_cnt_d;
    end
  end
`endif

  // Outputs
  assign WB_STALL     = stall_c;
  assign GPR_WE       = wr_en_c & ld_gpr1_q;
  assign GPR_DR       = dr1_q;
  assign GPR_DATA     = result_q;
  assign GPR_SIZE     = size_q;
  assign DCACHE_WE    = wr_en_c & dc_wr_q;
  assign DCACHE_WDATA = result_q;
  assign EFLAGS       = eflags_q;
  assign ECX_WE       = ecx_we_c;
  assign REP_REDIRECT = redirect_c;
`ifdef WB_REP_EN
  assign ECX_DATA     = ecx_new_c;
  assign REDIRECT_EIP = cur_eip_q;
`else
  assign ECX_DATA     = '0;
  assign REDIRECT_EIP = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback. Inputs are driven 1 time unit after each
// rising edge; outputs are checked in the same window.
module tb_writeback;

  logic        CLK, RST;
  logic        WB_V_next;
  logic [31:0] WB_CUR_EIP_next, WB_NEIP_next;
  logic [1:0]  WB_de_datasize_all_next;
  logic        WB_de_ld_gpr1_wb_next, WB_de_dcache_write_wb_next;
  logic [6:0]  WB_de_flags_affected_wb_next;
  logic [31:0] WB_ALU32_RESULT_next, WB_FLAGS_next, WB_COUNT_next;
  logic [2:0]  WB_DR1_next;
  logic        WB_IS_REP_next, WB_IS_REPNE_next, DCACHE_READY;
  logic        WB_STALL, GPR_WE, DCACHE_WE, ECX_WE, REP_REDIRECT;
  logic [2:0]  GPR_DR;
  logic [31:0] GPR_DATA, DCACHE_WDATA, ECX_DATA, EFLAGS, REDIRECT_EIP;
  logic [1:0]  GPR_SIZE;

  int n_cmp = 0;
  int n_mis = 0;

  writeback dut (
    .CLK(CLK), .RST(RST),
    .WB_V_next(WB_V_next),
    .WB_CUR_EIP_next(WB_CUR_EIP_next),
    .WB_NEIP_next(WB_NEIP_next),
    .WB_de_datasize_all_next(WB_de_datasize_all_next),
    .WB_de_ld_gpr1_wb_next(WB_de_ld_gpr1_wb_next),
    .WB_de_dcache_write_wb_next(WB_de_dcache_write_wb_next),
    .WB_de_flags_affected_wb_next(WB_de_flags_affected_wb_next),
    .WB_ALU32_RESULT_next(WB_ALU32_RESULT_next),
    .WB_FLAGS_next(WB_FLAGS_next),
    .WB_COUNT_next(WB_COUNT_next),
    .WB_DR1_next(WB_DR1_next),
    .WB_IS_REP_next(WB_IS_REP_next),
    .WB_IS_REPNE_next(WB_IS_REPNE_next),
    .DCACHE_READY(DCACHE_READY),
    .WB_STALL(WB_STALL),
    .GPR_WE(GPR_WE), .GPR_DR(GPR_DR), .GPR_DATA(GPR_DATA), .GPR_SIZE(GPR_SIZE),
    .DCACHE_WE(DCACHE_WE), .DCACHE_WDATA(DCACHE_WDATA),
    .ECX_WE(ECX_WE), .ECX_DATA(ECX_DATA),
    .EFLAGS(EFLAGS),
    .REP_REDIRECT(REP_REDIRECT), .REDIRECT_EIP(REDIRECT_EIP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WB_V_next = 1'b0;
    WB_CUR_EIP_next = '0;
    WB_NEIP_next = '0;
    WB_de_datasize_all_next = 2'b10;
    WB_de_ld_gpr1_wb_next = 1'b0;
    WB_de_dcache_write_wb_next = 1'b0;
    WB_de_flags_affected_wb_next = '0;
    WB_ALU32_RESULT_next = '0;
    WB_FLAGS_next = '0;
    WB_COUNT_next = '0;
    WB_DR1_next = '0;
    WB_IS_REP_next = 1'b0;
    WB_IS_REPNE_next = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    DCACHE_READY = 1'b1;
    idle();
    #2 RST = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_stall", 32'(WB_STALL), 32'd0);
    chk("rst_eflags", EFLAGS, 32'h0000_0002);
    chk("rst_gpr_we", 32'(GPR_WE), 32'd0);
    chk("rst_dc_we", 32'(DCACHE_WE), 32'd0);
    chk("rst_ecx_we", 32'(ECX_WE), 32'd0);
    chk("rst_redirect", 32'(REP_REDIRECT), 32'd0);
    RST = 1'b1;

    // ALU commit
    WB_V_next = 1'b1; WB_de_ld_gpr1_wb_next = 1'b1; WB_DR1_next = 3'd3;
    WB_ALU32_RESULT_next = 32'h1234; WB_de_flags_affected_wb_next = 7'h7F;
    WB_FLAGS_next = 32'h0000_0041; WB_de_datasize_all_next = 2'b01;
    tick();
    chk("alu_gpr_we", 32'(GPR_WE), 32'd1);
    chk("alu_gpr_dr", 32'(GPR_DR), 32'd3);
    chk("alu_gpr_data", GPR_DATA, 32'h1234);
    chk("alu_gpr_size", 32'(GPR_SIZE), 32'd1);
    chk("alu_eflags_pre", EFLAGS, 32'h0000_0002);
    idle();
    tick();
    chk("alu_eflags", EFLAGS, 32'h0000_0043);
    chk("alu_gpr_we_off", 32'(GPR_WE), 32'd0);

    // Partial mask: first set EFLAGS to 0x03, then update ZF only
    WB_V_next = 1'b1; WB_de_flags_affected_wb_next = 7'h7F; WB_FLAGS_next = 32'h1;
    tick(); idle(); tick();
    chk("pm_eflags_setup", EFLAGS, 32'h0000_0003);
    WB_V_next = 1'b1; WB_de_flags_affected_wb_next = 7'h08; WB_FLAGS_next = 32'h40;
    tick(); idle(); tick();
    chk("pm_eflags_zf", EFLAGS, 32'h0000_0043);

    // Dcache stall for 3 cycles, a second instruction waits at the latch input
    DCACHE_READY = 1'b0;
    WB_V_next = 1'b1; WB_de_dcache_write_wb_next = 1'b1;
    WB_ALU32_RESULT_next = 32'hCAFE_0001;
    tick();
    chk("st_c1_stall", 32'(WB_STALL), 32'd1);
    chk("st_c1_dc_we", 32'(DCACHE_WE), 32'd0);
    idle();
    WB_V_next = 1'b1; WB_de_ld_gpr1_wb_next = 1'b1; WB_DR1_next = 3'd5;
    WB_ALU32_RESULT_next = 32'h55;
    tick();
    chk("st_c2_stall", 32'(WB_STALL), 32'd1);
    chk("st_c2_dc_we", 32'(DCACHE_WE), 32'd0);
    chk("st_c2_gpr_we", 32'(GPR_WE), 32'd0);
    chk("st_c2_wdata", DCACHE_WDATA, 32'hCAFE_0001);
    tick();
    chk("st_c3_stall", 32'(WB_STALL), 32'd1);
    chk("st_c3_dc_we", 32'(DCACHE_WE), 32'd0);
    tick();
    DCACHE_READY = 1'b1;
    #1;
    chk("st_c4_stall", 32'(WB_STALL), 32'd0);
    chk("st_c4_dc_we", 32'(DCACHE_WE), 32'd1);
    chk("st_c4_wdata", DCACHE_WDATA, 32'hCAFE_0001);
    tick();
    chk("st_c5_gpr_we", 32'(GPR_WE), 32'd1);
    chk("st_c5_gpr_dr", 32'(GPR_DR), 32'd5);
    chk("st_c5_gpr_data", GPR_DATA, 32'h55);
    chk("st_c5_dc_we", 32'(DCACHE_WE), 32'd0);
    idle();
    tick();
    chk("st_eflags_hold", EFLAGS, 32'h0000_0043);

    // Reset during MEM_WAIT drops the blocked store
    DCACHE_READY = 1'b0;
    WB_V_next = 1'b1; WB_de_dcache_write_wb_next = 1'b1;
    WB_ALU32_RESULT_next = 32'hDEAD; WB_de_flags_affected_wb_next = 7'h7F;
    WB_FLAGS_next = 32'hFFF;
    tick();
    idle();
    tick();
    chk("rm_stall_pre", 32'(WB_STALL), 32'd1);
    RST = 1'b0;
    #1;
    chk("rm_stall", 32'(WB_STALL), 32'd0);
    chk("rm_eflags", EFLAGS, 32'h0000_0002);
    chk("rm_dc_we", 32'(DCACHE_WE), 32'd0);
    DCACHE_READY = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    chk("rm_dc_we_after", 32'(DCACHE_WE), 32'd0);
    chk("rm_eflags_after", EFLAGS, 32'h0000_0002);
    chk("rm_stall_after", 32'(WB_STALL), 32'd0);

`ifdef WB_REP_EN
    // REP, COUNT=3: redirect then two wrong-path instructions squashed
    WB_V_next = 1'b1; WB_IS_REP_next = 1'b1; WB_COUNT_next = 32'd3;
    WB_CUR_EIP_next = 32'h100; WB_de_ld_gpr1_wb_next = 1'b1; WB_DR1_next = 3'd7;
    WB_ALU32_RESULT_next = 32'hAA;
    tick();
    chk("rep3_ecx_we", 32'(ECX_WE), 32'd1);
    chk("rep3_ecx_data", ECX_DATA, 32'd2);
    chk("rep3_redirect", 32'(REP_REDIRECT), 32'd1);
    chk("rep3_eip", REDIRECT_EIP, 32'h100);
    chk("rep3_gpr_we", 32'(GPR_WE), 32'd1);
    idle();
    WB_V_next = 1'b1; WB_de_ld_gpr1_wb_next = 1'b1; WB_DR1_next = 3'd1;
    tick();
    chk("sq1_gpr_we", 32'(GPR_WE), 32'd0);
    chk("sq1_redirect", 32'(REP_REDIRECT), 32'd0);
    WB_DR1_next = 3'd2;
    tick();
    chk("sq2_gpr_we", 32'(GPR_WE), 32'd0);
    WB_DR1_next = 3'd4;
    tick();
    chk("post_sq_gpr_we", 32'(GPR_WE), 32'd1);
    chk("post_sq_gpr_dr", 32'(GPR_DR), 32'd4);

    // REP, COUNT=1: last iteration retires
    idle();
    WB_V_next = 1'b1; WB_IS_REP_next = 1'b1; WB_COUNT_next = 32'd1;
    WB_CUR_EIP_next = 32'h100;
    tick();
    chk("rep1_ecx_we", 32'(ECX_WE), 32'd1);
    chk("rep1_ecx_data", ECX_DATA, 32'd0);
    chk("rep1_redirect", 32'(REP_REDIRECT), 32'd0);

    // REPNE with ZF=1: early exit
    idle();
    WB_V_next = 1'b1; WB_IS_REPNE_next = 1'b1; WB_COUNT_next = 32'd5;
    WB_de_flags_affected_wb_next = 7'h08; WB_FLAGS_next = 32'h40;
    tick();
    chk("repne_ecx_we", 32'(ECX_WE), 32'd1);
    chk("repne_ecx_data", ECX_DATA, 32'd4);
    chk("repne_redirect", 32'(REP_REDIRECT), 32'd0);

    // REP, COUNT=0: zero-iteration retire, no writes at all
    idle();
    WB_V_next = 1'b1; WB_IS_REP_next = 1'b1; WB_COUNT_next = 32'd0;
    WB_de_ld_gpr1_wb_next = 1'b1; WB_de_dcache_write_wb_next = 1'b1;
    WB_de_flags_affected_wb_next = 7'h7F; WB_FLAGS_next = 32'hFFF;
    tick();
    chk("rep0_gpr_we", 32'(GPR_WE), 32'd0);
    chk("rep0_dc_we", 32'(DCACHE_WE), 32'd0);
    chk("rep0_ecx_we", 32'(ECX_WE), 32'd0);
    chk("rep0_redirect", 32'(REP_REDIRECT), 32'd0);
    idle();
    tick();
    chk("rep0_eflags", EFLAGS, 32'h0000_0042);
`else
    // REP prefix ignored: behaves as a plain instruction, no squash follows
    WB_V_next = 1'b1; WB_IS_REP_next = 1'b1; WB_COUNT_next = 32'd3;
    WB_CUR_EIP_next = 32'h100; WB_de_ld_gpr1_wb_next = 1'b1; WB_DR1_next = 3'd7;
    tick();
    chk("norep_ecx_we", 32'(ECX_WE), 32'd0);
    chk("norep_redirect", 32'(REP_REDIRECT), 32'd0);
    chk("norep_eip", REDIRECT_EIP, 32'd0);
    chk("norep_gpr_we", 32'(GPR_WE), 32'd1);
    idle();
    WB_V_next = 1'b1; WB_de_ld_gpr1_wb_next = 1'b1; WB_DR1_next = 3'd1;
    tick();
    chk("norep_next_gpr_we", 32'(GPR_WE), 32'd1);
    chk("norep_next_gpr_dr", 32'(GPR_DR), 32'd1);
    idle();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
